instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer_pkg.sv | 27 ++
 rtl/instruction_sequencer_decoder.sv | 30 +++
 rtl/instruction_sequencer.sv | 140 ++++++++++++++
 tb/tb_instruction_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared types for the instruction sequencer: FSM states, opcodes
// and bit positions inside the datapath control bus.
package instruction_sequencer_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_BEQ   = 2'b11;

    localparam int CTRL_REGDST   = 0;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_ALUOP    = 7;

endpackage

// File: rtl/instruction_sequencer_decoder.sv
// Opcode to static datapath control decode (pure combinational).
// Only the bits that hold for a whole instruction are produced here.
module seq_decoder
    import instruction_sequencer_pkg::*;
(
    input  logic [1:0] op_i,
    output logic [7:0] ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (op_i)
            OP_ADD: begin
                ctrl_o[CTRL_REGDST] = 1'b1;
                ctrl_o[CTRL_ALUOP]  = 1'b1;
            end
            OP_LOAD: begin
                ctrl_o[CTRL_ALUSRC]   = 1'b1;
                ctrl_o[CTRL_MEMTOREG] = 1'b1;
            end
            OP_STORE: begin
                ctrl_o[CTRL_ALUSRC] = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o[CTRL_BRANCH] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with pc and control bus.
// Define SEQ_MEM_TIMEOUT_EN to abandon data accesses after MEM_TIMEOUT cycles.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                clear,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [7:0]          imem_data,
    output logic [PC_WIDTH-1:0] pc,
    output logic [7:0]          ir,
    input  logic                alu_zero,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    output logic [7:0]          ctrl,
    output logic [2:0]          state,
    output logic                err
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic                err_q, err_d;
    logic [7:0]          static_ctrl;
    logic [7:0]          dyn_ctrl;
    logic [1:0]          op;
    logic [PC_WIDTH-1:0] br_off;

    assign op     = ir_q[7:6];
    assign br_off = {{(PC_WIDTH-2){ir_q[1]}}, ir_q[1:0]};

    seq_decoder u_dec (
        .op_i   (op),
        .ctrl_o (static_ctrl)
    );

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_hit;
    assign to_hit = (cnt_q == CW'(MEM_TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (MEM_TIMEOUT != 0);
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        err_d    = err_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        dyn_ctrl = '0;
`ifdef SEQ_MEM_TIMEOUT_EN
        cnt_d    = '0;
`endif
        unique case (state_q)
            S_FETCH: begin
                // held low while clear is asserted, rises on release
                imem_req = clear;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                unique case (op)
                    OP_ADD:   state_d = S_WB;
                    OP_LOAD,
                    OP_STORE: state_d = S_MEM;
                    OP_BEQ: begin
                        if (alu_zero)
                            pc_d = pc_q + br_off;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req                = 1'b1;
                dmem_we                 = (op == OP_STORE);
                dyn_ctrl[CTRL_MEMREAD]  = (op == OP_LOAD);
                dyn_ctrl[CTRL_MEMWRITE] = (op == OP_STORE);
                if (dmem_ack) begin
                    state_d = (op == OP_LOAD) ? S_WB : S_FETCH;
`ifdef SEQ_MEM_TIMEOUT_EN
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            S_WB: begin
                dyn_ctrl[CTRL_REGWRITE] = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

`ifdef SEQ_MEM_TIMEOUT_EN
    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`endif

    assign pc    = pc_q;
    assign ir    = ir_q;
    assign state = state_q;
    assign err   = err_q;
    assign ctrl  = (state_q == S_FETCH) ? 8'h00 : (static_ctrl | dyn_ctrl);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Table plus random checks of instruction_sequencer against an
// instruction-level model (cycle sequence, pc, ir, err, control bus).
module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int MEM_LIMIT = 15;
`else
    localparam int MEM_LIMIT = 32'h7fffffff;
`endif

    logic       clock = 1'b0;
    logic       clear;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       alu_zero;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic [7:0] ctrl;
    logic [2:0] state;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] pc_m;
    logic [7:0] ir_m;
    logic       err_m;

    typedef struct {
        logic [7:0] ins;
        int         fd;
        int         md;
        logic       z;
        logic [7:0] pc_after;
    } vec_t;

    vec_t tbl[12];

    instruction_sequencer #(.PC_WIDTH(8), .MEM_TIMEOUT(15)) dut (
        .clock     (clock),
        .clear     (clear),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .pc        (pc),
        .ir        (ir),
        .alu_zero  (alu_zero),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .ctrl      (ctrl),
        .state     (state),
        .err       (err)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] sctrl(input logic [1:0] op);
        case (op)
            2'd0:    return 8'h81;
            2'd1:    return 8'h06;
            2'd2:    return 8'h02;
            default: return 8'h40;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic noise();
        imem_ack  = 1'($urandom_range(0, 1));
        imem_data = 8'($urandom);
        dmem_ack  = 1'($urandom_range(0, 1));
        alu_zero  = 1'($urandom_range(0, 1));
    endtask

    task automatic expect_now(input string nm, input logic [2:0] st,
                              input logic [7:0] ct, input logic ireq,
                              input logic dreq, input logic dwe);
        logic [30:0] act;
        logic [30:0] exp;
        #1;
        act = {state, ctrl, imem_req, dmem_req, dmem_we, err, pc, ir};
        exp = {st, ct, ireq, dreq, dwe, err_m, pc_m, ir_m};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %h want %h (st,ctrl,ireq,dreq,we,err,pc,ir)",
                     nm, $time, act, exp);
        end
    endtask

    task automatic check_val(input string nm, input logic [7:0] act,
                             input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        #2 clear = 1'b0;
        pc_m  = 8'h00;
        ir_m  = 8'h00;
        err_m = 1'b0;
        expect_now("reset_async", S_FETCH, 8'h00, 1'b0, 1'b0, 1'b0);
        noise();
        tick();
        expect_now("reset_hold", S_FETCH, 8'h00, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
    endtask

    task automatic run_instr(input logic [7:0] ins, input int fd,
                             input int md, input logic z);
        logic [1:0] op;
        logic [7:0] sc;
        int         off;
        op = ins[7:6];
        sc = sctrl(op);
        for (int i = 0; i <= fd; i++) begin
            expect_now("fetch", S_FETCH, 8'h00, 1'b1, 1'b0, 1'b0);
            noise();
            imem_ack = (i == fd);
            if (i == fd)
                imem_data = ins;
            tick();
        end
        pc_m = 8'((int'(pc_m) + 1) % 256);
        ir_m = ins;
        expect_now("decode", S_DECODE, sc, 1'b0, 1'b0, 1'b0);
        noise();
        tick();
        expect_now("exec", S_EXEC, sc, 1'b0, 1'b0, 1'b0);
        noise();
        alu_zero = z;
        tick();
        if (op == 2'd3 && z) begin
            off  = (ins[1:0] >= 2) ? int'(ins[1:0]) - 4 : int'(ins[1:0]);
            pc_m = 8'((int'(pc_m) + off + 256) % 256);
        end
        if (op == 2'd1 || op == 2'd2) begin
            for (int j = 0; j <= md && j < MEM_LIMIT; j++) begin
                expect_now("mem", S_MEM, sc | ((op == 2'd1) ? 8'h10 : 8'h20),
                           1'b0, 1'b1, op == 2'd2);
                noise();
                dmem_ack = (j == md);
                tick();
            end
            if (md >= MEM_LIMIT)
                err_m = 1'b1;
        end
        if (op == 2'd0 || (op == 2'd1 && md < MEM_LIMIT)) begin
            expect_now("wb", S_WB, sc | 8'h08, 1'b0, 1'b0, 1'b0);
            noise();
            tick();
        end
    endtask

    initial begin
        tbl[0]  = '{8'hC2, 0, 0,  1'b1, 8'hFF};
        tbl[1]  = '{8'h1B, 0, 0,  1'b0, 8'h00};
        tbl[2]  = '{8'h46, 0, 3,  1'b0, 8'h01};
        tbl[3]  = '{8'h80, 1, 0,  1'b0, 8'h02};
        tbl[4]  = '{8'h1B, 2, 0,  1'b1, 8'h03};
        tbl[5]  = '{8'hC3, 0, 0,  1'b0, 8'h04};
        tbl[6]  = '{8'h4A, 0, 1,  1'b0, 8'h05};
        tbl[7]  = '{8'hC3, 0, 0,  1'b1, 8'h05};
        tbl[8]  = '{8'hC3, 0, 0,  1'b0, 8'h06};
        tbl[9]  = '{8'hC1, 0, 0,  1'b1, 8'h08};
        tbl[10] = '{8'h80, 0, 40, 1'b0, 8'h09};
        tbl[11] = '{8'h46, 0, 40, 1'b0, 8'h0A};

        clear = 1'b0;
        noise();
        pc_m  = 8'h00;
        ir_m  = 8'h00;
        err_m = 1'b0;
        tick();
        do_reset();

        for (int k = 0; k < 12; k++) begin
            run_instr(tbl[k].ins, tbl[k].fd, tbl[k].md, tbl[k].z);
            #1 check_val($sformatf("pc_after_%0d", k), pc, tbl[k].pc_after);
        end

        do_reset();
        run_instr(8'h1B, 0, 0, 1'b0);
        expect_now("st_fetch", S_FETCH, 8'h00, 1'b1, 1'b0, 1'b0);
        noise();
        imem_ack  = 1'b1;
        imem_data = 8'h80;
        tick();
        pc_m = 8'h02;
        ir_m = 8'h80;
        expect_now("st_decode", S_DECODE, 8'h02, 1'b0, 1'b0, 1'b0);
        noise();
        tick();
        expect_now("st_exec", S_EXEC, 8'h02, 1'b0, 1'b0, 1'b0);
        noise();
        tick();
        expect_now("st_mem", S_MEM, 8'h22, 1'b0, 1'b1, 1'b1);
        noise();
        dmem_ack = 1'b0;
        tick();
        do_reset();
        check_val("mid_mem_dreq", {7'd0, dmem_req}, 8'h00);

        for (int n = 0; n < 300; n++) begin
            run_instr(8'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end
        expect_now("final", S_FETCH, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
